dcache_linectrl: RTL and testbench



---
 rtl/dcache_linectrl_if.sv | 34 +++
 rtl/dcache_linectrl.sv | 142 ++++++++++++++
 tb/tb_dcache_linectrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_linectrl_if.sv
// Miss handshake and main-memory bus between tag logic, the line controller
// and the memory bus. The controller uses the master modport.
interface dcache_linectrl_if #(
  parameter int DATABITS      = 32,
  parameter int CACHEADDRBITS = 5,
  parameter int LINEWORDBITS  = 2,
  parameter int ADDRBITS      = 32
);
  logic                                    miss_req;
  logic                                    miss_dirty;
  logic [CACHEADDRBITS-LINEWORDBITS-1:0]   miss_line;
  logic [ADDRBITS-1:0]                     victim_addr;
  logic [ADDRBITS-1:0]                     fill_addr;
  logic                                    busy;
  logic                                    miss_done;
  logic [ADDRBITS-1:0]                     mem_addr;
  logic                                    mem_wrreq;
  logic [DATABITS-1:0]                     mem_wrdata;
  logic                                    mem_rdreq;
  logic                                    mem_ack;
  logic                                    mem_rdata_valid;

  modport master (
    input  miss_req, miss_dirty, miss_line, victim_addr, fill_addr,
    input  mem_ack, mem_rdata_valid,
    output busy, miss_done, mem_addr, mem_wrreq, mem_wrdata, mem_rdreq
  );

  modport slave (
    output miss_req, miss_dirty, miss_line, victim_addr, fill_addr,
    output mem_ack, mem_rdata_valid,
    input  busy, miss_done, mem_addr, mem_wrreq, mem_wrdata, mem_rdreq
  );
endinterface

// File: rtl/dcache_linectrl.sv
// Line-miss sequencer: writes back a dirty victim line word by word, refills
// the line from a memory read burst, then hands the memory block back to the CPU.
module dcache_linectrl #(
  parameter int DATABITS      = 32,
  parameter int CACHEADDRBITS = 5,
  parameter int LINEWORDBITS  = 2,
  parameter int ADDRBITS      = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  dcache_linectrl_if.master        bus,
  output logic                     flush_mode,
  output logic [CACHEADDRBITS-1:0] flush_addr,
  output logic                     flush_write,
  input  logic [DATABITS-1:0]      cache_rdata,
  output logic [2:0]               dbg_state
);
  localparam int LINEBITS = CACHEADDRBITS - LINEWORDBITS;
  localparam int LOWBITS  = LINEWORDBITS + 2;
  localparam logic [ADDRBITS-1:0] LINE_MASK = ~ADDRBITS'((2 ** LOWBITS) - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WB_RD     = 3'd1,
    S_WB_WR     = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_DATA = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t                  state, state_nx;
  logic [LINEWORDBITS-1:0] beat, beat_nx;
  logic [LINEBITS-1:0]     line_q;
  logic [ADDRBITS-1:0]     victim_q;
  logic [ADDRBITS-1:0]     fill_q;
  logic                    last_beat;
  logic [ADDRBITS-1:0]     beat_offset;

  assign last_beat   = (beat == {LINEWORDBITS{1'b1}});
  assign beat_offset = {{(ADDRBITS-LOWBITS){1'b0}}, beat, 2'b00};
  assign dbg_state   = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      beat     <= '0;
      line_q   <= '0;
      victim_q <= '0;
      fill_q   <= '0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      if (state == S_IDLE && bus.miss_req) begin
        line_q   <= bus.miss_line;
        victim_q <= bus.victim_addr & LINE_MASK;
        fill_q   <= bus.fill_addr & LINE_MASK;
      end
    end
  end

  // Bus handshake: mem_wrreq/mem_rdreq stay asserted with address and data
  // stable until mem_ack is sampled high; mem_ack is only consumed in WB_WR
  // and FILL_REQ, and mem_rdata_valid only in FILL_DATA.
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    unique case (state)
      S_IDLE: begin
        if (bus.miss_req) begin
          beat_nx  = '0;
          state_nx = bus.miss_dirty ? S_WB_RD : S_FILL_REQ;
        end
      end
      S_WB_RD: state_nx = S_WB_WR;
      S_WB_WR: begin
        if (bus.mem_ack) begin
          if (last_beat) begin
            beat_nx  = '0;
            state_nx = S_FILL_REQ;
          end else begin
            beat_nx  = beat + 1'b1;
            state_nx = S_WB_RD;
          end
        end
      end
      S_FILL_REQ: begin
        if (bus.mem_ack) state_nx = S_FILL_DATA;
      end
      S_FILL_DATA: begin
        if (bus.mem_rdata_valid) begin
          beat_nx = beat + 1'b1;
          if (last_beat) state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: begin
        state_nx = S_IDLE;
        beat_nx  = '0;
      end
    endcase
  end

  // Outputs decode from state only; mem_wrdata forwards the memory block's
  // registered read port, which was addressed during the preceding WB_RD.
  always_comb begin
    bus.busy       = (state != S_IDLE);
    bus.miss_done  = (state == S_DONE);
    bus.mem_addr   = '0;
    bus.mem_wrreq  = 1'b0;
    bus.mem_wrdata = '0;
    bus.mem_rdreq  = 1'b0;
    flush_mode     = 1'b0;
    flush_addr     = '0;
    flush_write    = 1'b0;
    unique case (state)
      S_WB_RD: begin
        flush_mode = 1'b1;
        flush_addr = {line_q, beat};
      end
      S_WB_WR: begin
        flush_mode     = 1'b1;
        flush_addr     = {line_q, beat};
        bus.mem_wrreq  = 1'b1;
        bus.mem_wrdata = cache_rdata;
        bus.mem_addr   = victim_q + beat_offset;
      end
      S_FILL_REQ: begin
        flush_mode    = 1'b1;
        flush_addr    = {line_q, beat};
        bus.mem_rdreq = 1'b1;
        bus.mem_addr  = fill_q;
      end
      S_FILL_DATA: begin
        flush_mode  = 1'b1;
        flush_addr  = {line_q, beat};
        flush_write = 1'b1;
      end
      default: begin
      end
    endcase
  end
endmodule

// File: tb/tb_dcache_linectrl.sv
// Directed bench for dcache_linectrl: memory-block RAM model, bus responder with
// programmable ack delay / beat gap, and a write/fill scoreboard.
module tb_dcache_linectrl;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WB_RD     = 3'd1;
  localparam logic [2:0] S_WB_WR     = 3'd2;
  localparam logic [2:0] S_FILL_DATA = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_mode, flush_write;
  logic [4:0]  flush_addr;
  logic [31:0] cache_rdata;
  logic [2:0]  dbg_state;

  dcache_linectrl_if #(.DATABITS(32), .CACHEADDRBITS(5), .LINEWORDBITS(2), .ADDRBITS(32)) bus ();

  dcache_linectrl #(.DATABITS(32), .CACHEADDRBITS(5), .LINEWORDBITS(2), .ADDRBITS(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .flush_mode  (flush_mode),
    .flush_addr  (flush_addr),
    .flush_write (flush_write),
    .cache_rdata (cache_rdata),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // bus responder and memory-block model signals
  logic        bus_ack = 1'b0, bus_valid = 1'b0, spur_ack, spur_valid;
  logic [31:0] bus_data = '0, spur_data, line_in;
  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram [32];
  logic [31:0] fill_data [4];
  logic [31:0] wb_data [4];
  logic [31:0] exp_fill;
  int          ack_delay, beat_gap;
  int          beats_left = 0, wait_cnt = 0, gap_cnt = 0, rd_cnt = 0;

  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  logic [4:0]  fa_q [$];

  assign bus.mem_ack         = bus_ack | spur_ack;
  assign bus.mem_rdata_valid = bus_valid | spur_valid;
  assign line_in             = spur_valid ? spur_data : bus_data;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (flush_mode && flush_write && bus.mem_rdata_valid) ram[flush_addr] <= line_in;
    cache_rdata <= ram[flush_addr];
  end

  always @(negedge clk) begin
    bus_ack   = 1'b0;
    bus_valid = 1'b0;
    if (!reset_n) begin
      beats_left = 0;
      wait_cnt   = 0;
      gap_cnt    = 0;
    end else begin
      if (bus.mem_wrreq) begin
        if (exp_addr_q.size() == 0) check_eq("extra_wr", 32'd1, 32'd0);
        else begin
          check_eq("wr_addr", bus.mem_addr, exp_addr_q[0]);
          check_eq("wr_data", bus.mem_wrdata, exp_data_q[0]);
        end
      end
      if (bus.mem_rdreq) check_eq("rd_addr", bus.mem_addr, exp_fill);
      if (beats_left != 0) begin
        if (gap_cnt == 0) begin
          bus_valid = 1'b1;
          bus_data  = fill_data[4-beats_left];
          if (fa_q.size() == 0) check_eq("extra_beat", 32'd1, 32'd0);
          else check_eq("fill_faddr", {27'd0, flush_addr}, {27'd0, fa_q.pop_front()});
          check_eq("fill_fwr", {31'd0, flush_write}, 32'd1);
          beats_left--;
          gap_cnt = beat_gap;
        end else gap_cnt--;
      end else if (bus.mem_wrreq || bus.mem_rdreq) begin
        if (wait_cnt == ack_delay) begin
          bus_ack  = 1'b1;
          wait_cnt = 0;
          if (bus.mem_rdreq) begin
            beats_left = 4;
            gap_cnt    = 0;
            rd_cnt++;
          end else if (exp_addr_q.size() != 0) begin
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
          end
        end else wait_cnt++;
      end
    end
  end

  // driver tasks
  task automatic preload(input int a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = 5'(a);
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"},   {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_done"},   {31'd0, bus.miss_done}, 32'd0);
    check_eq({tag, "_fmode"},  {31'd0, flush_mode}, 32'd0);
    check_eq({tag, "_fwr"},    {31'd0, flush_write}, 32'd0);
    check_eq({tag, "_faddr"},  {27'd0, flush_addr}, 32'd0);
    check_eq({tag, "_wrreq"},  {31'd0, bus.mem_wrreq}, 32'd0);
    check_eq({tag, "_rdreq"},  {31'd0, bus.mem_rdreq}, 32'd0);
    check_eq({tag, "_maddr"},  bus.mem_addr, 32'd0);
    check_eq({tag, "_wrdata"}, bus.mem_wrdata, 32'd0);
    check_eq({tag, "_state"},  {29'd0, dbg_state}, {29'd0, S_IDLE});
  endtask

  task automatic run_miss(input string tag, input logic dirty, input logic [2:0] line,
                          input logic [31:0] victim, input logic [31:0] fill,
                          input logic [31:0] victim_base, input logic [31:0] fill_base,
                          input int exp_cyc, input logic spur);
    int cyc, busy_n, rd0;
    exp_fill = fill_base;
    if (dirty) begin
      for (int i = 0; i < 4; i++) begin
        preload(int'(line) * 4 + i, wb_data[i]);
        exp_addr_q.push_back(victim_base + 32'(4 * i));
        exp_data_q.push_back(wb_data[i]);
      end
    end
    for (int i = 0; i < 4; i++) fa_q.push_back({line, i[1:0]});
    rd0 = rd_cnt;
    bus.miss_req    = 1'b1;
    bus.miss_dirty  = dirty;
    bus.miss_line   = line;
    bus.victim_addr = victim;
    bus.fill_addr   = fill;
    @(posedge clk);
    @(negedge clk);
    bus.miss_req = 1'b0;
    cyc    = 1;
    busy_n = 0;
    while (cyc <= 100) begin
      if (bus.busy) busy_n++;
      if (bus.miss_done) break;
      spur_ack = spur && (dbg_state == S_WB_RD);
      bus.miss_req = spur && (dbg_state == S_FILL_DATA);
      if (spur) begin
        bus.miss_line  = 3'd7;
        bus.miss_dirty = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    spur_ack     = 1'b0;
    bus.miss_req = 1'b0;
    check_eq({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, "_busy_cyc"}, 32'(busy_n), 32'(exp_cyc));
    @(negedge clk);
    check_eq({tag, "_post_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_post_state"}, {29'd0, dbg_state}, {29'd0, S_IDLE});
    check_eq({tag, "_wr_left"}, 32'(exp_addr_q.size()), 32'd0);
    check_eq({tag, "_beats_left"}, 32'(fa_q.size()), 32'd0);
    check_eq({tag, "_rd_reqs"}, 32'(rd_cnt - rd0), 32'd1);
    for (int i = 0; i < 4; i++)
      check_eq({tag, "_ram"}, ram[int'(line) * 4 + i], fill_data[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    bus.miss_req    = 1'b0;
    bus.miss_dirty  = 1'b0;
    bus.miss_line   = '0;
    bus.victim_addr = '0;
    bus.fill_addr   = '0;
    spur_ack        = 1'b0;
    spur_valid      = 1'b0;
    spur_data       = '0;
    pre_we          = 1'b0;
    pre_addr        = '0;
    pre_data        = '0;
    ack_delay       = 0;
    beat_gap        = 0;
    exp_fill        = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    preload(0, 32'h0BAD_0000);
    for (int i = 0; i < 4; i++) preload(28 + i, 32'h7700_0000 + 32'(i));

    // spurious beat and ack while idle
    spur_data  = 32'hDEAD_BEEF;
    spur_valid = 1'b1;
    spur_ack   = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    spur_ack   = 1'b0;
    @(negedge clk);
    check_eq("idle_spur_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check_eq("idle_spur_ram0", ram[0], 32'h0BAD_0000);

    for (int i = 0; i < 4; i++) fill_data[i] = 32'hA0 + 32'(i);
    run_miss("clean", 1'b0, 3'd3, 32'h0, 32'h1000, 32'h0, 32'h1000, 6, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wb_data[i]   = 32'h11 * 32'(i + 1);
      fill_data[i] = 32'hB0 + 32'(i);
    end
    run_miss("dirty", 1'b1, 3'd1, 32'h2000, 32'h3000, 32'h2000, 32'h3000, 14, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wb_data[i]   = 32'hC1 + 32'(i);
      fill_data[i] = 32'hD0 + 32'(i);
    end
    run_miss("wrap", 1'b1, 3'd2, 32'hFFFF_FFF3, 32'h1007, 32'hFFFF_FFF0, 32'h1000, 14, 1'b0);

    for (int i = 0; i < 4; i++) begin
      wb_data[i]   = 32'h61 + 32'(i);
      fill_data[i] = 32'hE0 + 32'(i);
    end
    run_miss("spur", 1'b1, 3'd6, 32'h7000, 32'h8000, 32'h7000, 32'h8000, 14, 1'b1);
    for (int i = 0; i < 4; i++)
      check_eq("spur_line7_ram", ram[28 + i], 32'h7700_0000 + 32'(i));

    ack_delay = 3;
    beat_gap  = 1;
    for (int i = 0; i < 4; i++) begin
      wb_data[i]   = 32'h51 + 32'(i);
      fill_data[i] = 32'hF0 + 32'(i);
    end
    run_miss("stall", 1'b1, 3'd5, 32'h5000, 32'h6000, 32'h5000, 32'h6000, 32, 1'b0);
    beat_gap = 0;

    // reset during the third write-back word, held in a stall
    for (int i = 0; i < 4; i++) begin
      preload(16 + i, 32'h4400_0000 + 32'(i));
      exp_addr_q.push_back(32'h4000 + 32'(4 * i));
      exp_data_q.push_back(32'h4400_0000 + 32'(i));
    end
    bus.miss_req    = 1'b1;
    bus.miss_dirty  = 1'b1;
    bus.miss_line   = 3'd4;
    bus.victim_addr = 32'h4000;
    bus.fill_addr   = 32'h4800;
    @(posedge clk);
    @(negedge clk);
    bus.miss_req = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("rst_mid_state", {29'd0, dbg_state}, {29'd0, S_WB_WR});
    check_eq("rst_mid_addr", bus.mem_addr, 32'h4008);
    check_eq("rst_mid_data", bus.mem_wrdata, 32'h4400_0002);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    @(negedge clk);
    exp_addr_q.delete();
    exp_data_q.delete();
    reset_n   = 1'b1;
    ack_delay = 0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) fill_data[i] = 32'h90 + 32'(i);
    run_miss("after_rst", 1'b0, 3'd3, 32'h0, 32'h9000, 32'h0, 32'h9000, 6, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
